// File: rtl/timer_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_regs_pkg
// Description : Address map, reset constants, TCR field layout and the
//               byte-strobe merge helper for the timer register file.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_regs_pkg;

    localparam logic [11:0] c_addr_tcr    = 12'h000;
    localparam logic [11:0] c_addr_tdr0   = 12'h004;
    localparam logic [11:0] c_addr_tdr1   = 12'h008;
    localparam logic [11:0] c_addr_tier   = 12'h014;
    localparam logic [11:0] c_addr_tisr   = 12'h018;
    localparam logic [11:0] c_addr_thcsr  = 12'h01C;
    localparam logic [11:0] c_chan_base   = 12'h100;
    localparam logic [11:0] c_chan_stride = 12'h010;

    localparam logic [63:0] c_rst_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] c_rst_per = 32'h0;

    localparam int          c_tcr_en_bit     = 0;
    localparam int          c_tcr_div_en_bit = 1;
    localparam int          c_tcr_div_lsb    = 8;
    localparam logic [3:0]  c_div_max        = 4'd8;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[b*8 +: 8] = {8{strb[b]}};
        end
        return (new_val & mask) | (old_val & ~mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_cmp_chan.sv
`default_nettype none
// ============================================================================
// Module      : timer_cmp_chan
// Description : One 64-bit compare channel with periodic reload and a sticky
//               status bit whose set beats a simultaneous software clear.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_cmp_chan
    import timer_regs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] i_cnt,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic        i_wr_per,
    input  logic        i_wr_ccr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_pstrb,
    input  logic        i_clr,
    output logic [63:0] o_cmp,
    output logic [31:0] o_per,
    output logic        o_periodic,
    output logic        o_status
);

    logic [63:0] r_cmp;
    logic [31:0] r_per;
    logic        r_periodic;
    logic        r_match_d;
    logic        r_status;

    logic        w_match;
    logic        w_rise;
    logic [63:0] w_cmp_rl;
    logic [63:0] w_cmp_nxt;

    always_comb begin
        w_match  = (i_cnt == r_cmp);
        w_rise   = w_match & ~r_match_d;
        w_cmp_rl = (w_rise && r_periodic) ? r_cmp + {32'h0, r_per} : r_cmp;
        // Software bytes land on top of the reloaded value
        w_cmp_nxt = w_cmp_rl;
        if (i_wr_lo) w_cmp_nxt[31:0]  = byte_merge(w_cmp_rl[31:0],  i_wdata, i_pstrb);
        if (i_wr_hi) w_cmp_nxt[63:32] = byte_merge(w_cmp_rl[63:32], i_wdata, i_pstrb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp      <= c_rst_cmp;
            r_per      <= c_rst_per;
            r_periodic <= 1'b0;
            r_match_d  <= 1'b0;
            r_status   <= 1'b0;
        end else begin
            r_cmp     <= w_cmp_nxt;
            r_match_d <= w_match;
            if (i_wr_per) r_per <= byte_merge(r_per, i_wdata, i_pstrb);
            if (i_wr_ccr && i_pstrb[0]) r_periodic <= i_wdata[0];
            if (w_rise)
                r_status <= 1'b1;
            else if (i_clr)
                r_status <= 1'b0;
        end
    end

    assign o_cmp      = r_cmp;
    assign o_per      = r_per;
    assign o_periodic = r_periodic;
    assign o_status   = r_status;

endmodule
`default_nettype wire

// File: rtl/timer_regfile_mc.sv
`default_nettype none
// ============================================================================
// Module      : timer_regfile_mc
// Description : Multi-channel timer register file: control, compare channels,
//               interrupt status, coherent 64-bit counter reads, debug halt.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_regfile_mc
    import timer_regs_pkg::*;
#(
    parameter int         NUM_CMP = 4,
    parameter logic [3:0] RST_DIV = 4'd1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [11:0]        addr,
    input  logic [31:0]        wdata,
    input  logic [3:0]         pstrb,
    input  logic               dbg_mode,
    input  logic [63:0]        cnt,
    output logic [31:0]        rdata,
    output logic               timer_en,
    output logic               div_en,
    output logic [3:0]         div_val,
    output logic               cnt_wr_lo,
    output logic               cnt_wr_hi,
    output logic [31:0]        cnt_wdata,
    output logic               halt_req,
    output logic [NUM_CMP-1:0] irq_vec,
    output logic               irq
);

    logic               r_timer_en;
    logic               r_div_en;
    logic [3:0]         r_div_val;
    logic [NUM_CMP-1:0] r_tier;
    logic               r_halt_req;
    logic               r_halt_ack;
    logic               r_snap_vld;
    logic [31:0]        r_shadow;

    logic w_wr_tcr, w_wr_tdr0, w_wr_tdr1, w_wr_tier, w_wr_tisr, w_wr_thcsr;
    logic w_rd_tdr0, w_rd_tdr1;
    logic [NUM_CMP-1:0] w_ch_hit;
    logic [NUM_CMP-1:0] w_tier_new;
    logic [NUM_CMP-1:0] w_clr;
    logic [NUM_CMP-1:0] w_status;
    logic [NUM_CMP-1:0] w_periodic;
    logic [63:0]        w_cmp [NUM_CMP];
    logic [31:0]        w_per [NUM_CMP];
    logic [3:0]         w_div_new;

    assign w_wr_tcr   = wr_en && (addr == c_addr_tcr);
    assign w_wr_tdr0  = wr_en && (addr == c_addr_tdr0);
    assign w_wr_tdr1  = wr_en && (addr == c_addr_tdr1);
    assign w_wr_tier  = wr_en && (addr == c_addr_tier);
    assign w_wr_tisr  = wr_en && (addr == c_addr_tisr);
    assign w_wr_thcsr = wr_en && (addr == c_addr_thcsr);
    assign w_rd_tdr0  = rd_en && (addr == c_addr_tdr0);
    assign w_rd_tdr1  = rd_en && (addr == c_addr_tdr1);

    assign w_tier_new = NUM_CMP'(byte_merge(32'(r_tier), wdata, pstrb));
    assign w_clr      = w_wr_tisr ? NUM_CMP'(wdata & byte_merge(32'h0, 32'hFFFF_FFFF, pstrb))
                                  : '0;
    assign w_div_new  = pstrb[c_tcr_div_lsb/8] ? wdata[c_tcr_div_lsb +: 4] : r_div_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer_en <= 1'b0;
            r_div_en   <= 1'b0;
            r_div_val  <= RST_DIV;
            r_tier     <= '0;
            r_halt_req <= 1'b0;
            r_halt_ack <= 1'b0;
            r_snap_vld <= 1'b0;
            r_shadow   <= 32'h0;
        end else begin
            if (w_wr_tcr) begin
                if (pstrb[0]) r_timer_en <= wdata[c_tcr_en_bit];
                // Divider settings are frozen while the timer runs
                if (!r_timer_en) begin
                    if (pstrb[0]) r_div_en <= wdata[c_tcr_div_en_bit];
                    if (w_div_new <= c_div_max) r_div_val <= w_div_new;
                end
            end
            if (w_wr_tier) r_tier <= w_tier_new;
            if (w_wr_thcsr && pstrb[0]) r_halt_req <= wdata[0];
            r_halt_ack <= dbg_mode & r_halt_req;
            if (w_rd_tdr0) begin
                r_shadow   <= cnt[63:32];
                r_snap_vld <= 1'b1;
            end
            if (w_rd_tdr1 || w_wr_tdr0 || w_wr_tdr1) r_snap_vld <= 1'b0;
        end
    end

    generate
        for (genvar i = 0; i < NUM_CMP; i++) begin : g_chan
            localparam logic [11:0] c_base = c_chan_base + c_chan_stride * 12'(i);

            assign w_ch_hit[i] = (addr[11:4] == c_base[11:4]) && (addr[1:0] == 2'b00);

            timer_cmp_chan u_chan (
                .clk        (clk),
                .rst        (rst),
                .i_cnt      (cnt),
                .i_wr_lo    (wr_en && w_ch_hit[i] && (addr[3:2] == 2'd0)),
                .i_wr_hi    (wr_en && w_ch_hit[i] && (addr[3:2] == 2'd1)),
                .i_wr_per   (wr_en && w_ch_hit[i] && (addr[3:2] == 2'd2)),
                .i_wr_ccr   (wr_en && w_ch_hit[i] && (addr[3:2] == 2'd3)),
                .i_wdata    (wdata),
                .i_pstrb    (pstrb),
                .i_clr      (w_clr[i]),
                .o_cmp      (w_cmp[i]),
                .o_per      (w_per[i]),
                .o_periodic (w_periodic[i]),
                .o_status   (w_status[i])
            );
        end
    endgenerate

    always_comb begin
        rdata = 32'h0;
        if (rd_en) begin
            case (addr)
                c_addr_tcr:   rdata = {20'h0, r_div_val, 6'h0, r_div_en, r_timer_en};
                c_addr_tdr0:  rdata = cnt[31:0];
                c_addr_tdr1:  rdata = r_snap_vld ? r_shadow : cnt[63:32];
                c_addr_tier:  rdata = 32'(r_tier);
                c_addr_tisr:  rdata = 32'(w_status);
                c_addr_thcsr: rdata = {30'h0, r_halt_ack, r_halt_req};
                default:      rdata = 32'h0;
            endcase
            for (int i = 0; i < NUM_CMP; i++) begin
                if (w_ch_hit[i]) begin
                    case (addr[3:2])
                        2'd0:    rdata = w_cmp[i][31:0];
                        2'd1:    rdata = w_cmp[i][63:32];
                        2'd2:    rdata = w_per[i];
                        default: rdata = {31'h0, w_periodic[i]};
                    endcase
                end
            end
        end
    end

    always_comb begin
        cnt_wdata = 32'h0;
        if (w_wr_tdr0)      cnt_wdata = byte_merge(cnt[31:0],  wdata, pstrb);
        else if (w_wr_tdr1) cnt_wdata = byte_merge(cnt[63:32], wdata, pstrb);
    end

    assign cnt_wr_lo = w_wr_tdr0;
    assign cnt_wr_hi = w_wr_tdr1;
    assign timer_en  = r_timer_en;
    assign div_en    = r_div_en;
    assign div_val   = r_div_val;
    assign halt_req  = r_halt_req;
    assign irq_vec   = w_status & r_tier;
    assign irq       = |irq_vec;

endmodule
`default_nettype wire
